// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: two-port round-robin arbiter and strobe sequencer for one asynchronous SRAM.
// Ports:
//   Clk_i, Reset_i            clock (rising edge) and asynchronous active-low reset
//   A_*_i / A_done_o          CPU requester: req, we, addr, wdata in; one-cycle done out
//   B_*_i / B_done_o          debug/loader requester, same shape as port A
//   rdata_o                   shared registered read data, valid from the done cycle onwards
//   Mem_din_i                 SRAM bus read data
//   Mem_dout_o, Mem_dout_en_o SRAM bus write data and its tristate enable
//   Mem_addr_o                registered SRAM address
//   Mem_CE/UB/LB/OE/WE_o      active-low SRAM strobes
module sram_port_arbiter #(
    parameter int ADDR_W       = 20,
    parameter int DATA_W       = 16,
    parameter int READ_CYCLES  = 2,
    parameter int WRITE_CYCLES = 2
) (
    input  logic              Clk_i,
    input  logic              Reset_i,
    input  logic              A_req_i,
    input  logic              A_we_i,
    input  logic [ADDR_W-1:0] A_addr_i,
    input  logic [DATA_W-1:0] A_wdata_i,
    output logic              A_done_o,
    input  logic              B_req_i,
    input  logic              B_we_i,
    input  logic [ADDR_W-1:0] B_addr_i,
    input  logic [DATA_W-1:0] B_wdata_i,
    output logic              B_done_o,
    output logic [DATA_W-1:0] rdata_o,
    input  logic [DATA_W-1:0] Mem_din_i,
    output logic [DATA_W-1:0] Mem_dout_o,
    output logic              Mem_dout_en_o,
    output logic [ADDR_W-1:0] Mem_addr_o,
    output logic              Mem_CE_o,
    output logic              Mem_UB_o,
    output logic              Mem_LB_o,
    output logic              Mem_OE_o,
    output logic              Mem_WE_o
);
    localparam int MAXC = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              gnt_b_q, gnt_b_d;
    logic              last_b_q, last_b_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              sel_b, rd_last, wr_last, busy;

    // B wins only when A is idle, or on a tie when A was served last
    assign sel_b   = B_req_i & (~A_req_i | ~last_b_q);
    assign rd_last = cnt_q == CW'(READ_CYCLES - 1);
    assign wr_last = cnt_q == CW'(WRITE_CYCLES - 1);
    assign busy    = (state_q == READ) || (state_q == WRITE);

    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            gnt_b_q  <= 1'b0;
            last_b_q <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gnt_b_q  <= gnt_b_d;
            last_b_q <= last_b_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gnt_b_d  = gnt_b_q;
        last_b_d = last_b_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: if (A_req_i | B_req_i) begin
                gnt_b_d  = sel_b;
                last_b_d = sel_b;
                addr_d   = sel_b ? B_addr_i : A_addr_i;
                wdata_d  = sel_b ? B_wdata_i : A_wdata_i;
                cnt_d    = '0;
                state_d  = (sel_b ? B_we_i : A_we_i) ? WRITE : READ;
            end
            READ: begin
                cnt_d = cnt_q + 1'b1;
                if (rd_last) begin
                    rdata_d = Mem_din_i;
                    state_d = DONE;
                end
            end
            WRITE: begin
                cnt_d = cnt_q + 1'b1;
                if (wr_last) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode from the registered state so reset forces them high at once
    assign Mem_CE_o      = ~busy;
    assign Mem_UB_o      = ~busy;
    assign Mem_LB_o      = ~busy;
    assign Mem_OE_o      = state_q != READ;
    // Last write cycle keeps data driven with WE high as recovery time
    assign Mem_WE_o      = ~((state_q == WRITE) && !wr_last);
    assign Mem_dout_en_o = state_q == WRITE;
    assign Mem_addr_o    = addr_q;
    assign Mem_dout_o    = wdata_q;
    assign rdata_o       = rdata_q;
    assign A_done_o      = (state_q == DONE) && !gnt_b_q;
    assign B_done_o      = (state_q == DONE) && gnt_b_q;
endmodule
